// File: rtl/vtimctl_pkg.sv
// Shared types and constants for the vertical timing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vtimctl_pkg;

    localparam int LINE_W         = 9;
    localparam int DEF_PAL_LINES  = 313;
    localparam int DEF_NTSC_LINES = 263;
    localparam int DEF_MONO_LINES = 501;
    localparam int DEF_VS_LEN     = 3;

    // Encoding matches the mode_sel pins directly.
    typedef enum logic [1:0] {
        MODE_PAL     = 2'b00,
        MODE_NTSC    = 2'b01,
        MODE_MONO    = 2'b10,
        MODE_INVALID = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DROP = 2'b10
    } state_e;

    function automatic logic mode_valid(input logic [1:0] sel);
        return sel != MODE_INVALID;
    endfunction

endpackage

// File: rtl/vline_cnt.sv
// Line counter with end-of-frame detect and vertical sync register.
// Latency: line/ivsync update on the hsync_stb edge; wrap is combinational on that cycle.
// Backpressure: none; counts every hsync_stb pulse.
//
// Ports: clk, por (sync active-high reset), hsync_stb (end of line),
//        last (lines per frame for the current mode) ->
//        line (current line), wrap (this hsync_stb ends the frame), ivsync.
module vline_cnt
    import vtimctl_pkg::*;
#(
    parameter int VS_LEN = DEF_VS_LEN
) (
    input  logic              clk,
    input  logic              por,
    input  logic              hsync_stb,
    input  logic [LINE_W-1:0] last,
    output logic [LINE_W-1:0] line,
    output logic              wrap,
    output logic              ivsync
);

    localparam logic [LINE_W:0] VS_LEN_W = (LINE_W+1)'(VS_LEN);

    logic [LINE_W:0] line_nxt;

    assign line_nxt = {1'b0, line} + 1'b1;

    // line+1 >= last covers both the normal LAST-1 wrap and any out-of-range
    // line left over from a shorter-frame mode switch.
    assign wrap = hsync_stb && (line_nxt >= {1'b0, last});

    always_ff @(posedge clk) begin
        if (por) begin
            line   <= '0;
            ivsync <= 1'b1;
        end else if (hsync_stb) begin
            if (wrap) begin
                line   <= '0;
                ivsync <= (VS_LEN_W != '0);
            end else begin
                line   <= line_nxt[LINE_W-1:0];
                ivsync <= (line_nxt < VS_LEN_W);
            end
        end
    end

endmodule

// File: rtl/vtimctl.sv
// Vertical timing controller: line counting plus frame-synchronous mode switching.
// Latency: mode_err one clk after request; mode_ack one clk after the applying frame wrap.
// Backpressure: busy stays high from acceptance until mode_req is dropped after ack/err.
//
// Ports: clk, por (sync active-high reset), hsync_stb, mode_req/mode_sel (request),
//        mode_ack/mode_err/busy (handshake), mde1/cpal/cntsc (active mode, one-hot),
//        ivsync, line, frame_stb.
module vtimctl
    import vtimctl_pkg::*;
#(
    parameter int PAL_LINES  = DEF_PAL_LINES,
    parameter int NTSC_LINES = DEF_NTSC_LINES,
    parameter int MONO_LINES = DEF_MONO_LINES,
    parameter int VS_LEN     = DEF_VS_LEN
) (
    input  logic              clk,
    input  logic              por,
    input  logic              hsync_stb,
    input  logic              mode_req,
    input  logic [1:0]        mode_sel,
    output logic              mode_ack,
    output logic              mode_err,
    output logic              busy,
    output logic              mde1,
    output logic              cpal,
    output logic              cntsc,
    output logic              ivsync,
    output logic [LINE_W-1:0] line,
    output logic              frame_stb
);

    state_e            state;
    mode_e             mode_act;
    mode_e             mode_pend;
    logic [LINE_W-1:0] last;
    logic              wrap;

    // Frame length follows the mode active before the edge, so the frame that
    // starts at a mode-change wrap already counts against the new length.
    always_comb begin
        last = LINE_W'(PAL_LINES);
        case (mode_act)
            MODE_NTSC: last = LINE_W'(NTSC_LINES);
            MODE_MONO: last = LINE_W'(MONO_LINES);
            default:   last = LINE_W'(PAL_LINES);
        endcase
    end

    vline_cnt #(
        .VS_LEN (VS_LEN)
    ) u_line (
        .clk       (clk),
        .por       (por),
        .hsync_stb (hsync_stb),
        .last      (last),
        .line      (line),
        .wrap      (wrap),
        .ivsync    (ivsync)
    );

    // A request accepted in IDLE on a wrap edge only reaches PEND after that
    // edge, so it naturally waits for the following wrap.
    always_ff @(posedge clk) begin
        if (por) begin
            state     <= ST_IDLE;
            mode_act  <= MODE_PAL;
            mode_pend <= MODE_PAL;
            mode_ack  <= 1'b0;
            mode_err  <= 1'b0;
            frame_stb <= 1'b0;
        end else begin
            mode_ack  <= 1'b0;
            mode_err  <= 1'b0;
            frame_stb <= wrap;
            case (state)
                ST_IDLE: begin
                    if (mode_req) begin
                        if (mode_valid(mode_sel)) begin
                            mode_pend <= mode_e'(mode_sel);
                            state     <= ST_PEND;
                        end else begin
                            mode_err <= 1'b1;
                            state    <= ST_DROP;
                        end
                    end
                end
                ST_PEND: begin
                    // mode_sel is deliberately not looked at here.
                    if (wrap) begin
                        mode_act <= mode_pend;
                        mode_ack <= 1'b1;
                        state    <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!mode_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // mode_act only ever holds a validated encoding, so this stays one-hot.
    assign cpal  = (mode_act == MODE_PAL);
    assign cntsc = (mode_act == MODE_NTSC);
    assign mde1  = (mode_act == MODE_MONO);

endmodule
